// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared types and constants for the pipeline hazard controller
package hazard_ctrl_pkg;
  localparam logic [4:0] REG_X0 = 5'd0;
  typedef enum logic [1:0] {HZ_RUN, HZ_STALL2, HZ_MWAIT} hz_state_e;
  typedef enum logic [2:0] {
    HZ_NONE,
    HZ_LOAD_USE,
    HZ_BR_ALU,
    HZ_BR_LOAD_EX,
    HZ_BR_LOAD_MEM,
    HZ_MEM_WAIT
  } hz_class_e;
endpackage

// File: rtl/hazard_match.sv
// hazard_match: compares one ID source register against the ID/EX and EX/MEM destinations
module hazard_match
  import hazard_ctrl_pkg::*;
(
  input  logic       id_valid,
  input  logic [4:0] rs,
  input  logic       use_rs,
  input  logic [4:0] ex_rd,
  input  logic       ex_reg_write,
  input  logic       ex_valid,
  input  logic [4:0] mem_rd,
  input  logic       mem_valid,
  output logic       m_ex,
  output logic       m_mem
);
  always_comb begin
    m_ex  = id_valid && use_rs && ex_valid && ex_reg_write && ex_rd != REG_X0 && ex_rd == rs;
    m_mem = id_valid && use_rs && mem_valid && mem_rd != REG_X0 && mem_rd == rs;
  end
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/bubble/flush generation for RAW hazards, memory wait and taken branches
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [4:0]       i_id_rs1,
  input  logic [4:0]       i_id_rs2,
  input  logic             i_id_use_rs1,
  input  logic             i_id_use_rs2,
  input  logic             i_id_valid,
  input  logic             i_id_is_branch,
  input  logic             i_id_branch_taken,
  input  logic [4:0]       i_id_ex_rd,
  input  logic             i_id_ex_reg_write,
  input  logic             i_id_ex_mem_read,
  input  logic             i_id_ex_valid,
  input  logic [4:0]       i_ex_mem_rd,
  input  logic             i_ex_mem_mem_read,
  input  logic             i_ex_mem_mem_op,
  input  logic             i_ex_mem_valid,
  input  logic             i_lsu_ready,
  output logic             o_stall_if,
  output logic             o_stall_id,
  output logic             o_bubble_ex,
  output logic             o_stall_ex,
  output logic             o_flush_id,
  output logic             o_mem_timeout,
  output logic [CNT_W-1:0] o_stall_cycles
);
  localparam int WT_W = $clog2(MEM_TIMEOUT);
  localparam logic [WT_W-1:0] WT_MAX = WT_W'(MEM_TIMEOUT - 1);
  hz_state_e state, state_nxt;
  hz_class_e cls;
  logic [WT_W-1:0] wait_cnt;
  logic ex1, ex2, mm1, mm2, m_ex, m_mem, mem_wait, data;
  hazard_match u_rs1 (
    .id_valid(i_id_valid), .rs(i_id_rs1), .use_rs(i_id_use_rs1),
    .ex_rd(i_id_ex_rd), .ex_reg_write(i_id_ex_reg_write), .ex_valid(i_id_ex_valid),
    .mem_rd(i_ex_mem_rd), .mem_valid(i_ex_mem_valid), .m_ex(ex1), .m_mem(mm1)
  );
  hazard_match u_rs2 (
    .id_valid(i_id_valid), .rs(i_id_rs2), .use_rs(i_id_use_rs2),
    .ex_rd(i_id_ex_rd), .ex_reg_write(i_id_ex_reg_write), .ex_valid(i_id_ex_valid),
    .mem_rd(i_ex_mem_rd), .mem_valid(i_ex_mem_valid), .m_ex(ex2), .m_mem(mm2)
  );
  // MWAIT behaves like RUN once the wait drops, so data hazards are re-evaluated with no dead cycle
  always_comb begin
    m_ex        = ex1 || ex2;
    m_mem       = mm1 || mm2;
    mem_wait    = i_ex_mem_valid && i_ex_mem_mem_op && !i_lsu_ready;
    cls         = mem_wait                                            ? HZ_MEM_WAIT
                : (i_id_is_branch && m_ex && i_id_ex_mem_read)        ? HZ_BR_LOAD_EX
                : (m_ex && i_id_ex_mem_read && !i_id_is_branch)       ? HZ_LOAD_USE
                : (i_id_is_branch && m_ex)                            ? HZ_BR_ALU
                : (i_id_is_branch && m_mem && i_ex_mem_mem_read)      ? HZ_BR_LOAD_MEM
                : HZ_NONE;
    data        = state == HZ_STALL2 || (cls != HZ_NONE && cls != HZ_MEM_WAIT);
    o_stall_ex  = mem_wait;
    o_stall_if  = mem_wait || data;
    o_stall_id  = mem_wait || data;
    o_bubble_ex = data && !mem_wait;
    o_flush_id  = i_id_valid && i_id_is_branch && i_id_branch_taken && !(mem_wait || data);
    state_nxt   = mem_wait ? (state == HZ_STALL2 ? HZ_STALL2 : HZ_MWAIT)
                : (state != HZ_STALL2 && cls == HZ_BR_LOAD_EX) ? HZ_STALL2 : HZ_RUN;
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state          <= HZ_RUN;
      wait_cnt       <= '0;
      o_mem_timeout  <= 1'b0;
      o_stall_cycles <= '0;
    end else begin
      state          <= state_nxt;
      wait_cnt       <= !mem_wait ? '0 : (wait_cnt == WT_MAX) ? wait_cnt : wait_cnt + WT_W'(1);
      o_mem_timeout  <= o_mem_timeout || (mem_wait && wait_cnt == WT_MAX);
      o_stall_cycles <= (o_stall_if && !(&o_stall_cycles)) ? o_stall_cycles + CNT_W'(1) : o_stall_cycles;
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed stimulus with a per-cycle reference model and literal spot checks
module tb_hazard_ctrl;
  localparam int TO = 64;
  localparam int CW = 32;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [4:0] id_rs1, id_rs2, idex_rd, exm_rd;
  logic use1, use2, id_valid, br, taken, idex_wr, idex_mr, idex_valid;
  logic exm_mr, exm_op, exm_valid, lsu_ready;
  logic stall_if, stall_id, bubble_ex, stall_ex, flush_id, mem_timeout;
  logic [CW-1:0] stall_cycles;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .i_clk(clk), .i_reset(reset),
    .i_id_rs1(id_rs1), .i_id_rs2(id_rs2), .i_id_use_rs1(use1), .i_id_use_rs2(use2),
    .i_id_valid(id_valid), .i_id_is_branch(br), .i_id_branch_taken(taken),
    .i_id_ex_rd(idex_rd), .i_id_ex_reg_write(idex_wr), .i_id_ex_mem_read(idex_mr),
    .i_id_ex_valid(idex_valid), .i_ex_mem_rd(exm_rd), .i_ex_mem_mem_read(exm_mr),
    .i_ex_mem_mem_op(exm_op), .i_ex_mem_valid(exm_valid), .i_lsu_ready(lsu_ready),
    .o_stall_if(stall_if), .o_stall_id(stall_id), .o_bubble_ex(bubble_ex),
    .o_stall_ex(stall_ex), .o_flush_id(flush_id), .o_mem_timeout(mem_timeout),
    .o_stall_cycles(stall_cycles)
  );
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
    end
  endtask
  function automatic bit hit(input logic [4:0] rs, input logic u, input logic [4:0] rd,
                             input logic wr, input logic v);
    return id_valid && u && v && wr && rd != 5'd0 && rd == rs;
  endfunction
  // reference model: pending second stall, wait run length, sticky timeout, stall count
  bit mv = 1'b0;
  bit pend2 = 1'b0;
  bit mto = 1'b0;
  int wrun = 0;
  longint mcnt = 0;
  bit e_mex, e_mmem, e_mw, e_blex, e_data, e_stall, e_bub, e_flush;
  always_comb begin
    e_mex   = hit(id_rs1, use1, idex_rd, idex_wr, idex_valid) || hit(id_rs2, use2, idex_rd, idex_wr, idex_valid);
    e_mmem  = hit(id_rs1, use1, exm_rd, 1'b1, exm_valid) || hit(id_rs2, use2, exm_rd, 1'b1, exm_valid);
    e_mw    = exm_valid && exm_op && !lsu_ready;
    e_blex  = br && e_mex && idex_mr;
    e_data  = pend2 || (e_mex && idex_mr && !br) || (br && e_mex && !idex_mr) || e_blex || (br && e_mmem && exm_mr);
    e_stall = e_mw || e_data;
    e_bub   = e_data && !e_mw;
    e_flush = id_valid && br && taken && !e_stall;
  end
  always @(negedge clk) begin
    if (mv) begin
      check("m_stall_if", stall_if, e_stall);
      check("m_stall_id", stall_id, e_stall);
      check("m_bubble_ex", bubble_ex, e_bub);
      check("m_stall_ex", stall_ex, e_mw);
      check("m_flush_id", flush_id, e_flush);
      check("m_timeout", mem_timeout, mto);
      check("m_stall_cycles", stall_cycles, mcnt);
    end
    if (reset) begin
      mv    <= 1'b1;
      pend2 <= 1'b0;
      mto   <= 1'b0;
      wrun  <= 0;
      mcnt  <= 0;
    end else begin
      pend2 <= pend2 ? e_mw : (e_blex && !e_mw);
      mto   <= mto || (e_mw && wrun + 1 >= TO);
      wrun  <= e_mw ? wrun + 1 : 0;
      mcnt  <= (e_stall && mcnt < 64'hFFFF_FFFF) ? mcnt + 1 : mcnt;
    end
  end
  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; use1 = 0; use2 = 0; id_valid = 0; br = 0; taken = 0;
    idex_rd = 0; idex_wr = 0; idex_mr = 0; idex_valid = 0;
    exm_rd = 0; exm_mr = 0; exm_op = 0; exm_valid = 0; lsu_ready = 1;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic lw_in_ex(input logic [4:0] rd);
    idex_valid = 1; idex_rd = rd; idex_wr = 1; idex_mr = 1;
  endtask
  task automatic lw_in_mem(input logic [4:0] rd);
    idex_valid = 0; exm_valid = 1; exm_rd = rd; exm_mr = 1; exm_op = 1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    idle();
    reset = 1;
    tick(); tick();
    reset = 0;
    #1;
    check("rst_stall", stall_if, 0);
    check("rst_cnt", stall_cycles, 0);
    check("rst_timeout", mem_timeout, 0);
    tick();
    // lw x5 ; add x6,x5,x1
    lw_in_ex(5); id_valid = 1; id_rs1 = 5; use1 = 1; id_rs2 = 1; use2 = 1;
    #1;
    check("lu_stall", stall_if, 1);
    check("lu_bubble", bubble_ex, 1);
    check("lu_stall_ex", stall_ex, 0);
    tick();
    lw_in_mem(5);
    #1;
    check("lu_after", stall_if, 0);
    check("lu_cnt", stall_cycles, 1);
    tick(); idle(); tick();
    // lw x7 ; beq x7,x0 taken
    lw_in_ex(7); id_valid = 1; br = 1; taken = 1; id_rs1 = 7; use1 = 1; id_rs2 = 0; use2 = 1;
    #1;
    check("bl1_stall", stall_if, 1);
    check("bl1_flush", flush_id, 0);
    tick();
    lw_in_mem(7);
    #1;
    check("bl2_stall", stall_id, 1);
    check("bl2_bubble", bubble_ex, 1);
    check("bl2_flush", flush_id, 0);
    tick();
    exm_valid = 0;
    #1;
    check("bl3_stall", stall_if, 0);
    check("bl3_flush", flush_id, 1);
    check("bl_cnt", stall_cycles, 3);
    tick(); idle();
    // add x3 ; bne x3
    idex_valid = 1; idex_rd = 3; idex_wr = 1; id_valid = 1; br = 1; id_rs1 = 3; use1 = 1;
    #1;
    check("alu_stall", stall_if, 1);
    tick();
    idex_valid = 0; exm_valid = 1; exm_rd = 3;
    #1;
    check("alu_after", stall_if, 0);
    check("alu_cnt", stall_cycles, 4);
    tick(); idle();
    // add x0 ; bne x0 (with a load to x0 in MEM as well)
    idex_valid = 1; idex_rd = 0; idex_wr = 1; id_valid = 1; br = 1; id_rs1 = 0; use1 = 1;
    exm_valid = 1; exm_rd = 0; exm_mr = 1; exm_op = 1;
    #1;
    check("x0_stall", stall_if, 0);
    tick(); idle();
    // 70-cycle memory wait with a taken branch waiting in ID
    exm_valid = 1; exm_op = 1; lsu_ready = 0;
    id_valid = 1; br = 1; taken = 1; id_rs1 = 1; use1 = 1;
    for (int i = 0; i < 70; i++) begin
      #1;
      check("mw_stall_ex", stall_ex, 1);
      check("mw_flush", flush_id, 0);
      check("mw_timeout", mem_timeout, (i >= 64) ? 1 : 0);
      tick();
    end
    lsu_ready = 1;
    #1;
    check("mw_end_stall_ex", stall_ex, 0);
    check("mw_end_flush", flush_id, 1);
    check("mw_end_timeout", mem_timeout, 1);
    check("mw_cnt", stall_cycles, 74);
    tick(); idle();
    #1;
    check("mw_sticky", mem_timeout, 1);
    tick();
    // lw x7 ; beq x7 with memory wait during the second stall cycle
    lw_in_ex(7); id_valid = 1; br = 1; id_rs1 = 7; use1 = 1;
    #1;
    check("s2_first", bubble_ex, 1);
    tick();
    lw_in_mem(7); lsu_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("s2_freeze_ex", stall_ex, 1);
      check("s2_freeze_bub", bubble_ex, 0);
      tick();
    end
    lsu_ready = 1;
    #1;
    check("s2_resume_stall", stall_if, 1);
    check("s2_resume_bub", bubble_ex, 1);
    tick();
    exm_valid = 0;
    #1;
    check("s2_done", stall_if, 0);
    check("s2_cnt", stall_cycles, 79);
    tick(); idle();
    // reset while in STALL2
    lw_in_ex(7); id_valid = 1; br = 1; id_rs1 = 7; use1 = 1;
    #1;
    check("rs2_enter", stall_if, 1);
    tick();
    idle(); reset = 1;
    #1;
    check("rs2_hold", stall_if, 1);
    tick();
    reset = 0;
    #1;
    check("rs2_stall", stall_if, 0);
    check("rs2_cnt", stall_cycles, 0);
    check("rs2_timeout", mem_timeout, 0);
    tick(); tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard/stall controller for the 5-stage core: the complement of the operand-forwarding logic.
- Detects every RAW case that EX/MEM and MEM/WB forwarding cannot satisfy, plus memory wait and taken-branch redirect.
- Generates stall, bubble and flush controls for the IF/ID, ID/EX and EX/MEM registers.
- Keeps a small FSM for multi-cycle stalls, a memory-wait timeout and a saturating stall-cycle counter.

Parameters:
- MEM_TIMEOUT, 64, cycles of continuous memory wait before o_mem_timeout is set; must be >= 2.
- CNT_W, 32, width of o_stall_cycles.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous active-high reset.
- i_id_rs1  in  5  ID-stage source register 1.
- i_id_rs2  in  5  ID-stage source register 2.
- i_id_use_rs1  in  1  ID instruction reads rs1.
- i_id_use_rs2  in  1  ID instruction reads rs2.
- i_id_valid  in  1  IF/ID holds a valid instruction.
- i_id_is_branch  in  1  ID instruction is a branch/jalr compared in ID.
- i_id_branch_taken  in  1  ID branch resolved taken (valid only when not stalled).
- i_id_ex_rd  in  5  destination register in ID/EX.
- i_id_ex_reg_write  in  1  ID/EX instruction writes rd.
- i_id_ex_mem_read  in  1  ID/EX instruction is a load.
- i_id_ex_valid  in  1  ID/EX valid and not a bubble.
- i_ex_mem_rd  in  5  destination register in EX/MEM.
- i_ex_mem_mem_read  in  1  EX/MEM instruction is a load.
- i_ex_mem_mem_op  in  1  EX/MEM instruction is a load or store.
- i_ex_mem_valid  in  1  EX/MEM valid and not a bubble.
- i_lsu_ready  in  1  LSU completes the MEM-stage access this cycle.
- o_stall_if  out  1  hold PC.
- o_stall_id  out  1  hold IF/ID.
- o_bubble_ex  out  1  load a bubble into ID/EX.
- o_stall_ex  out  1  hold ID/EX and EX/MEM (memory wait).
- o_flush_id  out  1  kill IF/ID contents next edge.
- o_mem_timeout  out  1  sticky memory-wait timeout flag.
- o_stall_cycles  out  CNT_W  saturating count of cycles with o_stall_if=1.

Behaviour:
- Source match:
  - m_ex(rs) = i_id_ex_valid && i_id_ex_reg_write && rd!=0 && rd==rs && rs is used.
  - m_mem(rs) is the same test on EX/MEM with i_ex_mem_valid.
  - Both are gated by i_id_valid.
- Hazard classes, evaluated in state RUN:
  - LOAD_USE: m_ex && i_id_ex_mem_read && !i_id_is_branch → 1 stall cycle.
  - BR_ALU: i_id_is_branch && m_ex && !i_id_ex_mem_read → 1 stall cycle.
  - BR_LOAD_EX: i_id_is_branch && m_ex && i_id_ex_mem_read → 2 stall cycles: this cycle, then state STALL2.
  - BR_LOAD_MEM: i_id_is_branch && m_mem && i_ex_mem_mem_read → 1 stall cycle.
  - MEM_WAIT: i_ex_mem_valid && i_ex_mem_mem_op && !i_lsu_ready → whole-pipe freeze.
- Data stall (any data-stall class active): o_stall_if=o_stall_id=1, o_bubble_ex=1, o_stall_ex=0.
- Freeze (MEM_WAIT): o_stall_if=o_stall_id=o_stall_ex=1, o_bubble_ex=0. Has priority over every data stall; a data stall is re-evaluated after the freeze ends.
- Flush: o_flush_id=1 when i_id_valid && i_id_is_branch && i_id_branch_taken and no stall or freeze is active this cycle. It is never asserted together with o_stall_id.
- All control outputs are combinational from registered state plus current inputs: zero-latency stall.
- FSM states:
  - RUN→STALL2 on BR_LOAD_EX without MEM_WAIT.
  - STALL2: data-stall outputs asserted. STALL2→RUN next cycle, unless MEM_WAIT; while MEM_WAIT holds, stay in STALL2 with freeze outputs.
  - RUN→MWAIT when MEM_WAIT. MWAIT→RUN the cycle MEM_WAIT deasserts. Outputs in MWAIT follow the freeze rule.
- Wait counter:
  - Increments each cycle MEM_WAIT holds; clears when it drops.
  - On reaching MEM_TIMEOUT-1 while still waiting, o_mem_timeout sets next edge.
  - o_mem_timeout is sticky until reset; the counter saturates.
- o_stall_cycles: +1 each cycle o_stall_if=1; holds at all-ones.
- Reset, taking effect at the edge even mid-stall:
  - State → RUN; wait counter → 0.
  - o_mem_timeout → 0; o_stall_cycles → 0.
  - Combinational outputs then reflect RUN with current inputs.
- Register x0 never creates a hazard.

Decomposition:
- Add to the shared core package:
  - hz_state_e {HZ_RUN, HZ_STALL2, HZ_MWAIT}.
  - REG_X0 constant.
  - stall-class enum, used for debug/trace.
- One sub-module: hazard_match, a combinational m_ex/m_mem comparator instantiated for rs1 and rs2.
- FSM and counters stay in hazard_ctrl.

Test Plan:
- Load-use: ID/EX `lw x5`, ID `add x6,x5,x1` → exactly 1 cycle with stall_if=stall_id=bubble_ex=1; next cycle all 0; o_stall_cycles=1.
- Branch after load: ID/EX `lw x7`, ID `beq x7,x0` → 2 consecutive stall cycles (RUN then STALL2), then flush if taken; o_stall_cycles=2.
- ALU→branch and rd=x0: `add x3` then `bne x3` → 1 stall. `add x0` then `bne x0` → no stall.
- MEM wait + timeout: i_lsu_ready=0 for 70 cycles, MEM_TIMEOUT=64 → stall_ex=1 for all 70 cycles, o_mem_timeout=1 from cycle 64 and held after ready returns.
- Simultaneous events: taken branch in ID while MEM_WAIT active → flush_id=0 during freeze, flush_id=1 on first unfrozen cycle.
- Reset asserted in STALL2 → next cycle state RUN, counters 0, no stall with idle inputs.
